// File: rtl/register_writeback.sv
// register_writeback: 8-entry register file with a write-back front end.
// Accepts single-register writes or load-multiple writes (a destination
// bitmap filled one data word per cycle in ascending index order), offers
// two combinational read ports with same-cycle write bypass, and reports
// completion with a registered one-cycle done pulse.
module register_writeback #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic                    wb_multi,
    input  logic [ADDR_W-1:0]       wb_rd,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic [(2**ADDR_W)-1:0]  wb_mask,
    input  logic                    md_valid,
    output logic                    md_ready,
    input  logic [DATA_W-1:0]       md_data,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    output logic [DATA_W-1:0]       rd_data_a,
    output logic [DATA_W-1:0]       rd_data_b,
    output logic                    busy,
    output logic                    done
);

    localparam int NREG = 2**ADDR_W;

    typedef logic [NREG-1:0] mask_t;
    typedef enum logic {IDLE, MULTI} state_t;

    state_t              state;
    state_t              state_next;
    mask_t               pending;
    mask_t               pending_next;
    mask_t               pending_left;
    mask_t               target_onehot;
    logic [ADDR_W-1:0]   target;
    logic                accept;
    logic                md_fire;
    logic                done_next;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   regs [NREG];

    // Lowest set pending bit selects the next register of a load-multiple.
    always_comb begin
        target = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (pending[i]) begin
                target = ADDR_W'(i);
            end
        end
    end

    assign target_onehot = mask_t'(1) << target;
    assign pending_left  = pending & ~target_onehot;

    // Handshakes are withheld during flush so nothing is accepted in that cycle.
    assign wb_ready = (state == IDLE)  && !flush;
    assign md_ready = (state == MULTI) && !flush;
    assign busy     = (state == MULTI);
    assign accept   = wb_valid && wb_ready;
    assign md_fire  = md_valid && md_ready;

    // Select the single write port source; reset suppresses any commit so the
    // bypass never forwards a write that will not land.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wb_rd;
        wr_data = wb_data;
        if (resetn) begin
            if (state == IDLE && accept && !wb_multi) begin
                wr_en = 1'b1;
            end else if (md_fire) begin
                wr_en   = 1'b1;
                wr_addr = target;
                wr_data = md_data;
            end
        end
    end

    // Next-state, pending mask and completion pulse; flush overrides everything.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        done_next    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (wb_multi && (wb_mask != '0)) begin
                        state_next   = MULTI;
                        pending_next = wb_mask;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            MULTI: begin
                if (md_fire) begin
                    pending_next = pending_left;
                    if (pending_left == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
        if (flush) begin
            state_next   = IDLE;
            pending_next = '0;
            done_next    = 1'b0;
        end
    end

    // Control state: FSM, pending bitmap and the done pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            pending <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            done    <= done_next;
        end
    end

    // Register file: R[i] resets to i+1 except the top entry, which resets to 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == NREG - 1) ? '0 : DATA_W'(i + 1);
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports forward a write committing at the coming edge.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: tb/tb_register_writeback.sv
// Self-checking bench for register_writeback: directed scenarios plus a
// randomized run, all checked against a queue-based behavioural model.
module tb_register_writeback;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic              flush;
    logic              wb_valid;
    logic              wb_ready;
    logic              wb_multi;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [NREG-1:0]   wb_mask;
    logic              md_valid;
    logic              md_ready;
    logic [DATA_W-1:0] md_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy;
    logic              done;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: register contents, queue of remaining multi targets,
    // and the completion pulse expected after the last edge.
    logic [DATA_W-1:0] m_r [NREG];
    int                m_q [$];
    bit                m_done;

    register_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_multi(wb_multi),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_mask(wb_mask),
        .md_valid(md_valid), .md_ready(md_ready), .md_data(md_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] reset_val(int i);
        return (i == NREG - 1) ? '0 : DATA_W'(i + 1);
    endfunction

    // Which write (if any) the model says commits at the coming edge.
    function automatic void exp_commit(output bit en, output int a, output logic [DATA_W-1:0] d);
        en = 0; a = 0; d = '0;
        if (!resetn || flush) return;
        if (m_q.size() == 0) begin
            if (wb_valid && !wb_multi) begin en = 1; a = int'(wb_rd); d = wb_data; end
        end else if (md_valid) begin
            en = 1; a = m_q[0]; d = md_data;
        end
    endfunction

    function automatic logic [DATA_W-1:0] exp_read(logic [ADDR_W-1:0] addr);
        bit en; int a; logic [DATA_W-1:0] d;
        exp_commit(en, a, d);
        if (en && a == int'(addr)) return d;
        return m_r[addr];
    endfunction

    // Advance one clock and apply the request semantics to the model.
    task automatic tick();
        bit en; int a; logic [DATA_W-1:0] d; bit was_busy;
        exp_commit(en, a, d);
        was_busy = (m_q.size() != 0);
        @(posedge clk);
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) m_r[i] = reset_val(i);
            m_q.delete();
            m_done = 0;
        end else if (flush) begin
            m_q.delete();
            m_done = 0;
        end else if (!was_busy) begin
            m_done = wb_valid && (!wb_multi || wb_mask == '0);
            if (wb_valid && wb_multi)
                for (int i = 0; i < NREG; i++) if (wb_mask[i]) m_q.push_back(i);
            if (en) m_r[a] = d;
        end else begin
            m_done = 0;
            if (en) begin
                m_r[a] = d;
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 0; wb_valid = 0; wb_multi = 0; wb_rd = '0; wb_data = '0;
        wb_mask = '0; md_valid = 0; md_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        tick();
        resetn = 1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready got %b want 1", wb_ready); end
        n_cmp++; if (md_ready !== 1'b0) begin n_fail++; $display("FAIL reset_md_ready got %b want 0", md_ready); end
        for (int i = 0; i < NREG; i++) begin
            rd_addr_a = ADDR_W'(i);
            rd_addr_b = ADDR_W'(NREG - 1 - i);
            #1;
            n_cmp++;
            if (rd_data_a !== reset_val(i)) begin
                n_fail++; $display("FAIL reset_read_a[%0d] got %h want %h", i, rd_data_a, reset_val(i));
            end
            n_cmp++;
            if (rd_data_b !== reset_val(NREG - 1 - i)) begin
                n_fail++; $display("FAIL reset_read_b[%0d] got %h want %h", NREG - 1 - i, rd_data_b, reset_val(NREG - 1 - i));
            end
        end
    endtask

    task automatic test_single();
        idle_inputs();
        wb_valid = 1; wb_multi = 0; wb_rd = 3; wb_data = 16'hABCD; rd_addr_a = 3; rd_addr_b = 4;
        #1;
        n_cmp++; if (rd_data_a !== 16'hABCD) begin n_fail++; $display("FAIL single_bypass got %h want abcd", rd_data_a); end
        n_cmp++; if (rd_data_b !== 16'h0005) begin n_fail++; $display("FAIL single_other_port got %h want 0005", rd_data_b); end
        tick();
        wb_valid = 0;
        #1;
        n_cmp++; if (rd_data_a !== 16'hABCD) begin n_fail++; $display("FAIL single_stored got %h want abcd", rd_data_a); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done got %b want 1", done); end
        tick();
        #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse got %b want 0", done); end
    endtask

    task automatic test_multi_gap();
        bit               vld [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [DATA_W-1:0] dat [4] = '{16'h1111, 16'hFFFF, 16'h2222, 16'h3333};
        logic [DATA_W-1:0] r1, r2, r4;
        int low_cnt = 0;
        idle_inputs();
        r1 = m_r[1]; r2 = m_r[2]; r4 = m_r[4];
        wb_valid = 1; wb_multi = 1; wb_mask = 8'h29;
        tick();
        wb_valid = 0; wb_multi = 0; wb_mask = '0;
        for (int c = 0; c < 4; c++) begin
            md_valid = vld[c]; md_data = dat[c];
            #1;
            if (wb_ready === 1'b0) low_cnt++;
            n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++; $display("FAIL multi_gap_cycle%0d busy/done got %b/%b want 1/0", c, busy, done);
            end
            tick();
        end
        md_valid = 0;
        #1;
        n_cmp++; if (low_cnt != 4) begin n_fail++; $display("FAIL multi_gap_ready_low got %0d cycles want 4", low_cnt); end
        n_cmp++; if (done !== 1'b1 || wb_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL multi_gap_end done/ready/busy got %b/%b/%b want 1/1/0", done, wb_ready, busy);
        end
        rd_addr_a = 0; rd_addr_b = 3; #1;
        n_cmp++; if (rd_data_a !== 16'h1111 || rd_data_b !== 16'h2222) begin
            n_fail++; $display("FAIL multi_gap_r0_r3 got %h/%h want 1111/2222", rd_data_a, rd_data_b);
        end
        rd_addr_a = 5; rd_addr_b = 1; #1;
        n_cmp++; if (rd_data_a !== 16'h3333 || rd_data_b !== r1) begin
            n_fail++; $display("FAIL multi_gap_r5_r1 got %h/%h want 3333/%h", rd_data_a, rd_data_b, r1);
        end
        rd_addr_a = 2; rd_addr_b = 4; #1;
        n_cmp++; if (rd_data_a !== r2 || rd_data_b !== r4) begin
            n_fail++; $display("FAIL multi_gap_untouched got %h/%h want %h/%h", rd_data_a, rd_data_b, r2, r4);
        end
        tick();
        #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL multi_gap_single_pulse got %b want 0", done); end
    endtask

    task automatic test_multi_flush();
        logic [DATA_W-1:0] snap [NREG];
        idle_inputs();
        for (int i = 0; i < NREG; i++) snap[i] = m_r[i];
        wb_valid = 1; wb_multi = 1; wb_mask = 8'hFF;
        tick();
        wb_valid = 0; wb_multi = 0; wb_mask = '0;
        for (int w = 0; w < 3; w++) begin
            md_valid = 1; md_data = 16'hA000 + DATA_W'(w);
            tick();
        end
        flush = 1; md_valid = 1; md_data = 16'hDEAD; rd_addr_a = 3;
        #1;
        n_cmp++; if (rd_data_a !== snap[3] || md_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_bypass got %h/%b want %h/0", rd_data_a, md_ready, snap[3]);
        end
        tick();
        flush = 0; md_valid = 0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || wb_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_idle busy/done/ready got %b/%b/%b want 0/0/1", busy, done, wb_ready);
        end
        for (int i = 0; i < NREG; i++) begin
            logic [DATA_W-1:0] want;
            want = (i < 3) ? 16'hA000 + DATA_W'(i) : snap[i];
            rd_addr_a = ADDR_W'(i); #1;
            n_cmp++; if (rd_data_a !== want) begin
                n_fail++; $display("FAIL flush_reg[%0d] got %h want %h", i, rd_data_a, want);
            end
        end
        tick();
        #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_late_done got %b want 0", done); end
    endtask

    task automatic test_multi_zero();
        logic [DATA_W-1:0] snap [NREG];
        idle_inputs();
        for (int i = 0; i < NREG; i++) snap[i] = m_r[i];
        wb_valid = 1; wb_multi = 1; wb_mask = 8'h00;
        tick();
        wb_valid = 0; wb_multi = 0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b1) begin
            n_fail++; $display("FAIL zero_mask busy/done got %b/%b want 0/1", busy, done);
        end
        for (int i = 0; i < NREG; i++) begin
            rd_addr_b = ADDR_W'(i); #1;
            n_cmp++; if (rd_data_b !== snap[i]) begin
                n_fail++; $display("FAIL zero_mask_reg[%0d] got %h want %h", i, rd_data_b, snap[i]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_multi();
        idle_inputs();
        wb_valid = 1; wb_multi = 1; wb_mask = 8'h0F;
        tick();
        wb_valid = 0; wb_multi = 0; wb_mask = '0;
        md_valid = 1; md_data = 16'h5555;
        tick();
        resetn = 0; md_data = 16'h7777;
        tick();
        resetn = 1; md_valid = 0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || wb_ready !== 1'b1 || md_ready !== 1'b0) begin
            n_fail++; $display("FAIL midreset_ctrl busy/done/wbr/mdr got %b/%b/%b/%b want 0/0/1/0",
                               busy, done, wb_ready, md_ready);
        end
        for (int i = 0; i < NREG; i++) begin
            rd_addr_a = ADDR_W'(i); #1;
            n_cmp++; if (rd_data_a !== reset_val(i)) begin
                n_fail++; $display("FAIL midreset_reg[%0d] got %h want %h", i, rd_data_a, reset_val(i));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            resetn    = ($urandom_range(0, 59) != 0);
            flush     = ($urandom_range(0, 11) == 0);
            wb_valid  = $urandom_range(0, 1);
            wb_multi  = $urandom_range(0, 1);
            wb_rd     = ADDR_W'($urandom_range(0, NREG - 1));
            wb_data   = DATA_W'($urandom);
            wb_mask   = ($urandom_range(0, 4) == 0) ? '0 : NREG'($urandom);
            md_valid  = ($urandom_range(0, 3) != 0);
            md_data   = DATA_W'($urandom);
            rd_addr_a = ADDR_W'($urandom_range(0, NREG - 1));
            rd_addr_b = ADDR_W'($urandom_range(0, NREG - 1));
            #1;
            n_cmp++;
            if (wb_ready !== (m_q.size() == 0 && !flush) || md_ready !== (m_q.size() != 0 && !flush)
                || busy !== (m_q.size() != 0) || done !== m_done) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc %0d wbr/mdr/busy/done got %b%b%b%b want %b%b%b%b", c,
                         wb_ready, md_ready, busy, done,
                         (m_q.size() == 0 && !flush), (m_q.size() != 0 && !flush), (m_q.size() != 0), m_done);
            end
            n_cmp++;
            if (rd_data_a !== exp_read(rd_addr_a) || rd_data_b !== exp_read(rd_addr_b)) begin
                n_fail++;
                $display("FAIL rand_read cyc %0d a/b got %h/%h want %h/%h", c,
                         rd_data_a, rd_data_b, exp_read(rd_addr_a), exp_read(rd_addr_b));
            end
            tick();
        end
        resetn = 1;
        idle_inputs();
    endtask

    initial begin
        resetn = 0;
        m_done = 0;
        for (int i = 0; i < NREG; i++) m_r[i] = reset_val(i);
        idle_inputs();
        test_reset();
        test_single();
        test_multi_gap();
        test_multi_flush();
        test_multi_zero();
        test_reset_mid_multi();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
